// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
//
// Shared definitions for the SPI master controller:
//   - spi_ctrl_state_t : controller state encoding
//   - SPI_BYTE_W       : width of one transfer unit
//   - SPI_CPOL/CPHA    : bus mode (mode 0: sclk idles low, sample on rise)
//   - spi_shift_in     : MSB-first receive shift helper
// ---------------------------------------------------------------------------
package spi_pkg;

  localparam int SPI_BYTE_W = 8;

  // Mode 0 bus behaviour.
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_LOW,
    ST_WAIT,
    ST_HOLD,
    ST_GAP
  } spi_ctrl_state_t;

  // With CPHA=0 the master samples in the phase that follows the leading
  // (first) sclk edge, which for CPOL=0 is the high phase.
  localparam spi_ctrl_state_t SPI_SAMPLE_STATE = (SPI_CPHA == 1'b0) ? ST_HIGH : ST_LOW;

  // Shift one received bit into the LSB; the first bit received ends up in
  // the MSB after a full byte.
  function automatic logic [SPI_BYTE_W-1:0] spi_shift_in(
    input logic [SPI_BYTE_W-1:0] sr,
    input logic                  bit_in
  );
    return {sr[SPI_BYTE_W-2:0], bit_in};
  endfunction

endpackage

// File: rtl/spi_sclk_div.sv
// ---------------------------------------------------------------------------
// spi_sclk_div
//
// Loadable half-period down-counter. A load of value N makes the phase last
// N+1 cycles: the counter runs N..0 and done_o is high in the final cycle of
// the phase. Once at zero the counter rests there until the next load.
//
// Ports:
//   clk        in  : system clock
//   rst        in  : synchronous active-high reset
//   load_i     in  : reload the counter (phase entry)
//   load_val_i in  : reload value (half-period minus one)
//   count_o    out : current count, equals load_val_i in the first phase cycle
//   done_o     out : last cycle of the current phase
// ---------------------------------------------------------------------------
module spi_sclk_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [DIV_W-1:0] load_val_i,
  output logic [DIV_W-1:0] count_o,
  output logic             done_o
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;
  assign done_o  = (cnt_q == '0);

endmodule

// File: rtl/spi_master_ctrl.sv
// ---------------------------------------------------------------------------
// spi_master_ctrl
//
// Byte-oriented SPI mode-0 master. Bytes arrive over a valid/ready handshake,
// are framed under cs_n, shifted MSB-first on mosi, and the byte sampled from
// miso is returned as a one-cycle rx_valid strobe (no backpressure).
// All bus outputs are registered; sclk half-period is clk_div+1 cycles,
// captured at each byte accept.
//
// Build option:
//   SPI_CTRL_BURST_EN : when defined, tx_last=0 keeps cs_n low and parks in
//                       WAIT for the next byte (multi-byte frames). When not
//                       defined, tx_last is ignored and every byte is framed
//                       on its own.
//
// Ports:
//   clk, rst           : system clock, synchronous active-high reset
//   clk_div            : sclk half-period minus one
//   tx_valid/tx_ready  : transmit handshake
//   tx_data, tx_last   : byte to send, end-of-frame marker
//   rx_valid, rx_data  : received byte strobe and value
//   busy               : controller not idle
//   sclk, cs_n, mosi   : SPI bus outputs
//   miso               : SPI bus input
// ---------------------------------------------------------------------------
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int DIV_W  = 8,
  parameter int CS_GAP = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIV_W-1:0]      clk_div,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [SPI_BYTE_W-1:0] tx_data,
  input  logic                  tx_last,
  output logic                  rx_valid,
  output logic [SPI_BYTE_W-1:0] rx_data,
  output logic                  busy,
  output logic                  sclk,
  output logic                  cs_n,
  output logic                  mosi,
  input  logic                  miso
);

  localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  spi_ctrl_state_t state_q;

  logic [DIV_W-1:0]      div_q;
  logic [SPI_BYTE_W-1:0] tx_sr_q;
  logic [SPI_BYTE_W-1:0] rx_sr_q;
  logic [2:0]            bit_cnt_q;
  logic [GAP_W-1:0]      gap_cnt_q;

  logic                  tx_ready_q;
  logic                  cs_n_q;
  logic                  sclk_q;
  logic                  mosi_q;
  logic                  rx_valid_q;
  logic [SPI_BYTE_W-1:0] rx_data_q;
  logic                  busy_q;

`ifdef SPI_CTRL_BURST_EN
  logic                  last_q;
`else
  logic                  unused_tx_last;
  assign unused_tx_last = tx_last;
`endif

  logic                  accept;
  logic                  div_load;
  logic [DIV_W-1:0]      div_load_val;
  logic [DIV_W-1:0]      div_count;
  logic                  div_done;
  logic                  sample_now;
  logic [SPI_BYTE_W-1:0] rx_shift;

  assign accept = tx_valid & tx_ready_q;

  // Every timed phase (SETUP/HIGH/LOW/HOLD) is entered either from an accept
  // or from the end of another timed phase; reload at both points. On an
  // accept the fresh clk_div is used because div_q is only written then.
  assign div_load     = accept |
                        (div_done & (state_q inside {ST_SETUP, ST_HIGH, ST_LOW}));
  assign div_load_val = accept ? clk_div : div_q;

  spi_sclk_div #(
    .DIV_W (DIV_W)
  ) u_sclk_div (
    .clk        (clk),
    .rst        (rst),
    .load_i     (div_load),
    .load_val_i (div_load_val),
    .count_o    (div_count),
    .done_o     (div_done)
  );

  // The counter equals the reload value only in the first cycle of a phase,
  // so miso is captured exactly once per high phase.
  assign sample_now = (state_q == SPI_SAMPLE_STATE) & (div_count == div_q);
  assign rx_shift   = spi_shift_in(rx_sr_q, miso);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      div_q      <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      tx_ready_q <= 1'b0;
      cs_n_q     <= 1'b1;
      sclk_q     <= SPI_CPOL;
      mosi_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      busy_q     <= 1'b0;
`ifdef SPI_CTRL_BURST_EN
      last_q     <= 1'b0;
`endif
    end else begin
      rx_valid_q <= 1'b0;

      if (sample_now) begin
        rx_sr_q <= rx_shift;
      end

      case (state_q)
        ST_IDLE: begin
          tx_ready_q <= 1'b1;
          busy_q     <= 1'b0;
          if (accept) begin
            state_q    <= ST_SETUP;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            tx_sr_q    <= tx_data;
            div_q      <= clk_div;
            bit_cnt_q  <= 3'd7;
            cs_n_q     <= 1'b0;
            sclk_q     <= SPI_CPOL;
            mosi_q     <= tx_data[SPI_BYTE_W-1];
`ifdef SPI_CTRL_BURST_EN
            last_q     <= tx_last;
`endif
          end
        end

        ST_SETUP: begin
          if (div_done) begin
            state_q <= ST_HIGH;
            sclk_q  <= ~SPI_CPOL;
          end
        end

        ST_HIGH: begin
          if (div_done) begin
            sclk_q    <= SPI_CPOL;
            // 3-bit counter wraps 0 -> 7, ready for the next byte.
            bit_cnt_q <= bit_cnt_q - 3'd1;
            if (bit_cnt_q == 3'd0) begin
              // With a one-cycle high phase the final bit is captured in
              // this same cycle, so take it from the shift path directly.
              rx_valid_q <= 1'b1;
              rx_data_q  <= sample_now ? rx_shift : rx_sr_q;
`ifdef SPI_CTRL_BURST_EN
              if (last_q) begin
                state_q <= ST_HOLD;
              end else begin
                state_q    <= ST_WAIT;
                tx_ready_q <= 1'b1;
              end
`else
              state_q <= ST_HOLD;
`endif
            end else begin
              state_q <= ST_LOW;
              tx_sr_q <= tx_sr_q << 1;
              mosi_q  <= tx_sr_q[SPI_BYTE_W-2];
            end
          end
        end

        ST_LOW: begin
          if (div_done) begin
            state_q <= ST_HIGH;
            sclk_q  <= ~SPI_CPOL;
          end
        end

`ifdef SPI_CTRL_BURST_EN
        ST_WAIT: begin
          // cs_n stays asserted; sclk stays idle until the next byte.
          tx_ready_q <= 1'b1;
          if (accept) begin
            state_q    <= ST_SETUP;
            tx_ready_q <= 1'b0;
            tx_sr_q    <= tx_data;
            div_q      <= clk_div;
            bit_cnt_q  <= 3'd7;
            mosi_q     <= tx_data[SPI_BYTE_W-1];
            last_q     <= tx_last;
          end
        end
`endif

        ST_HOLD: begin
          if (div_done) begin
            state_q   <= ST_GAP;
            cs_n_q    <= 1'b1;
            mosi_q    <= 1'b0;
            gap_cnt_q <= GAP_W'(CS_GAP - 1);
          end
        end

        ST_GAP: begin
          if (gap_cnt_q == '0) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            tx_ready_q <= 1'b1;
          end else begin
            gap_cnt_q <= gap_cnt_q - GAP_W'(1);
          end
        end

        default: begin
          state_q    <= ST_IDLE;
          busy_q     <= 1'b0;
          tx_ready_q <= 1'b0;
          cs_n_q     <= 1'b1;
          sclk_q     <= SPI_CPOL;
          mosi_q     <= 1'b0;
        end
      endcase
    end
  end

  assign tx_ready = tx_ready_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign busy     = busy_q;
  assign sclk     = sclk_q;
  assign cs_n     = cs_n_q;
  assign mosi     = mosi_q;

endmodule

// File: doc/spi_master_ctrl.md
# spi_master_ctrl

Byte-oriented SPI master controller that sequences chip-select, serial clock and data for the team's SPI slave datapath, running entirely in the system clock domain. It accepts transmit bytes over a valid/ready handshake, frames them under `cs_n`, shifts MSB-first on `mosi`, samples `miso`, and returns each received byte as a one-cycle strobe. It is SPI mode 0: `sclk` idles low, the master samples on the rising edge, and the slave shifts on the falling edge.

## Interface
- Parameters
  - `DIV_W`, default 8: width of `clk_div`.
  - `CS_GAP`, default 2: minimum clk cycles `cs_n` stays high between frames (≥1).
- Ports
  - `clk` in 1: system clock; all logic is on its rising edge.
  - `rst` in 1: synchronous, active-high reset.
  - `clk_div` in DIV_W: sclk half-period H = `clk_div`+1 clk cycles; sampled at byte accept.
  - `tx_valid` in 1: a transmit byte is offered.
  - `tx_ready` out 1: the controller can accept a byte.
  - `tx_data` in 8: byte to send, MSB first.
  - `tx_last` in 1: this byte ends the frame; only honoured with the burst feature.
  - `rx_valid` out 1: one-cycle strobe, `rx_data` is valid.
  - `rx_data` out 8: received byte.
  - `busy` out 1: high whenever state ≠ IDLE.
  - `sclk`, `cs_n`, `mosi` out 1: SPI bus, all registered.
  - `miso` in 1: SPI bus input.

## Operation
- States: IDLE, SETUP, HIGH, LOW, WAIT, HOLD, GAP.
- IDLE: `tx_ready`=1. On `tx_valid`&&`tx_ready`, latch `tx_data`, `tx_last` and `clk_div`, then go to SETUP.
- SETUP (H cycles): `cs_n`=0, `sclk`=0, `mosi`=bit 7. Then go to HIGH.
- HIGH (H cycles): `sclk`=1. `miso` is shifted into the rx register in the first HIGH cycle. Then go to LOW.
- LOW (H cycles): `sclk`=0, `mosi`=next bit. There are 7 LOW phases, between bits 7..0. After the 8th HIGH, the byte is complete.
- Byte complete, at the cycle `sclk` falls after bit 0: `rx_valid`=1 and `rx_data` is updated. `rx_valid` has no backpressure; a missed byte is lost.
- After the byte:
  - If the byte was last, or the burst feature is absent: go to HOLD.
  - Otherwise go to WAIT.
- WAIT: `cs_n`=0, `sclk`=0, `tx_ready`=1. An accepted byte goes to SETUP, with `cs_n` held low. It waits indefinitely.
- HOLD (H cycles): `sclk`=0, `cs_n`=0. Then go to GAP.
- GAP (CS_GAP cycles): `cs_n`=1, `mosi`=0. Then go to IDLE.
- Bit counter is 3 bits wide and wraps 0→7 per byte. The half-period counter is DIV_W bits and reloads from the latched `clk_div` at every phase entry.
- Changes to `clk_div` while busy are ignored.

## Timing
- Reset values:
  - `cs_n`=1, `sclk`=0, `mosi`=0.
  - `tx_ready`=0 during reset, 1 in the cycle after reset deasserts.
  - `rx_valid`=0, `rx_data`=0x00, `busy`=0.
- For an accept in cycle T:
  - `cs_n` falls at T+1.
  - First `sclk` rise at T+1+H; the sclk period is 2H.
  - `rx_valid` at T+1+16H.
  - `cs_n` rises at T+1+17H.
  - `tx_ready` returns at T+1+17H+CS_GAP.
- Burst accept in WAIT at cycle W: the next byte's first `sclk` rise is at W+1+H.
- Reset asserted mid-transfer: all outputs take their reset values in the next cycle (`cs_n`=1 immediately). The partial byte is discarded and no `rx_valid` is issued.
- `tx_valid` held while not ready: no effect. `tx_data` is only sampled at the handshake.

## Configuration
- Macro: `SPI_CTRL_BURST_EN`.
- Defined: `tx_last`=0 keeps `cs_n` low and enters WAIT between bytes, enabling multi-byte frames.
- Undefined:
  - `tx_last` is ignored and the WAIT state is not built.
  - Every byte is its own frame: SETUP…HOLD, GAP.

## Structure
- Package `spi_pkg`:
  - State enum `spi_ctrl_state_t`.
  - Localparam `SPI_BYTE_W`=8.
  - Mode constants CPOL=0, CPHA=0.
- Sub-module `spi_sclk_div`: loadable half-period down-counter with a phase-done pulse. All other logic stays in `spi_master_ctrl`.

## Test plan
The bench connects the team's SPI slave model on `sclk`/`cs_n`/`mosi`/`miso`.
- **Single byte:** `clk_div`=0, send 0x3C with `tx_last`=1 → `rx_data`=0xAA and `rx_valid` at T+17; `cs_n` is low for exactly 17 cycles; `mosi` bit sequence is 0,0,1,1,1,1,0,0.
- **Divider:** `clk_div`=3, send 0x81 → `sclk` period is 8 cycles; `rx_valid` at T+65; changing `clk_div` mid-byte has no effect.
- **Burst (EN):** send 0x3C with `tx_last`=0, then 0x5A with `tx_last`=1 → received bytes 0xAA then 0x3C; `cs_n` never rises between the bytes.
- **No EN:** the same two bytes → both return 0xAA; `cs_n` is high for ≥CS_GAP cycles between them.
- **Back-to-back:** `tx_valid` held continuously → `tx_ready` pulses once per frame; no byte is lost or duplicated.
- **Reset mid-byte:** assert `rst` at bit 4 → next cycle `cs_n`=1, `sclk`=0, no `rx_valid`; the following transfer of 0x3C returns 0xAA.
